// File: rtl/strait_pkg.sv
// strait_pkg: shared definitions for the row match sequencer.
//   DEFAULT_SYSTOLIC_SIZE : default array rows/columns
//   DEFAULT_ADDR_WIDTH    : row index width derived from the array size
//   seq_state_t           : matching FSM states
package strait_pkg;

  localparam int DEFAULT_SYSTOLIC_SIZE = 8;
  localparam int DEFAULT_ADDR_WIDTH    = $clog2(DEFAULT_SYSTOLIC_SIZE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ROW = 2'd1,
    SCAN     = 2'd2,
    ISSUE    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fault_row_storage.sv
// fault_row_storage: per-physical-row fault column bitmaps.
//   clk, rst         : clock, synchronous active-high reset (clears all bitmaps)
//   wr_en/wr_row/wr_cols : write port, bitmap of row wr_row replaced by wr_cols
//   rd_row/rd_cols   : combinational indexed read port
//   faulty_rows_mask : bit r set when row r has any faulty column
module fault_row_storage
  import strait_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = DEFAULT_SYSTOLIC_SIZE,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_WIDTH-1:0]    wr_row,
  input  logic [SYSTOLIC_SIZE-1:0] wr_cols,
  input  logic [ADDR_WIDTH-1:0]    rd_row,
  output logic [SYSTOLIC_SIZE-1:0] rd_cols,
  output logic [SYSTOLIC_SIZE-1:0] faulty_rows_mask
);

  logic [SYSTOLIC_SIZE-1:0] bitmap [SYSTOLIC_SIZE];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < SYSTOLIC_SIZE; r++) bitmap[r] <= '0;
    end else if (wr_en) begin
      bitmap[wr_row] <= wr_cols;
    end
  end

  always_comb begin
    faulty_rows_mask = '0;
    for (int r = 0; r < SYSTOLIC_SIZE; r++) faulty_rows_mask[r] = |bitmap[r];
  end

  assign rd_cols = bitmap[rd_row];

endmodule

// File: rtl/row_match_sequencer.sv
// row_match_sequencer: matches logical weight rows to faulty physical rows.
// A logical row whose zero-weight columns cover every faulty column of a
// physical row can be mapped onto that row; the lowest such row wins.
//   clk, rst                 : clock, synchronous active-high reset
//   load_valid/load_row/load_fault_cols : bitmap load (accepted in IDLE only)
//   start                    : begin a pass of SYSTOLIC_SIZE logical rows
//   row_valid/row_ready/zero_col_mask   : logical row handshake
//   match_success/match_failed/all_faulty_matched : one-cycle result pulses
//   faulty_addr, current_row_addr : matched physical row, logical row counter
//   faulty_rows_mask, wr_en, busy, done : status
//   success_count/failed_count : pulse statistics when MATCH_STATS_EN is
//                                defined, tied to zero otherwise
module row_match_sequencer
  import strait_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = DEFAULT_SYSTOLIC_SIZE,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  input  logic [ADDR_WIDTH-1:0]    load_row,
  input  logic [SYSTOLIC_SIZE-1:0] load_fault_cols,
  input  logic                     start,
  input  logic                     row_valid,
  output logic                     row_ready,
  input  logic [SYSTOLIC_SIZE-1:0] zero_col_mask,
  output logic                     match_success,
  output logic                     match_failed,
  output logic                     all_faulty_matched,
  output logic [ADDR_WIDTH-1:0]    faulty_addr,
  output logic [ADDR_WIDTH-1:0]    current_row_addr,
  output logic [SYSTOLIC_SIZE-1:0] faulty_rows_mask,
  output logic                     wr_en,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_WIDTH:0]      success_count,
  output logic [ADDR_WIDTH:0]      failed_count
);

  seq_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]    scan_idx;
  logic [ADDR_WIDTH-1:0]    row_cnt;
  logic [ADDR_WIDTH-1:0]    faulty_addr_q;
  logic [SYSTOLIC_SIZE-1:0] matched;
  logic [SYSTOLIC_SIZE-1:0] zmask;
  logic [SYSTOLIC_SIZE-1:0] rd_cols;
  logic [SYSTOLIC_SIZE-1:0] open_rows;
  logic                     hit_q;
  logic                     none_left_q;
  logic                     done_q;
  logic                     wr_en_q;
  logic                     load_acc;
  logic                     cand;
  logic                     last_scan;
  logic                     last_row;

  assign load_acc  = load_valid && (state == IDLE);
  assign open_rows = faulty_rows_mask & ~matched;
  // A row qualifies when every faulty column lines up with a zero weight.
  assign cand      = open_rows[scan_idx] && ((rd_cols & ~zmask) == '0);
  assign last_scan = (scan_idx == ADDR_WIDTH'(SYSTOLIC_SIZE - 1));
  assign last_row  = (row_cnt == ADDR_WIDTH'(SYSTOLIC_SIZE - 1));

  fault_row_storage #(
    .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) u_storage (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (load_acc),
    .wr_row           (load_row),
    .wr_cols          (load_fault_cols),
    .rd_row           (scan_idx),
    .rd_cols          (rd_cols),
    .faulty_rows_mask (faulty_rows_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = WAIT_ROW;
      // With nothing left to match the scan would be pointless.
      WAIT_ROW: if (row_valid) state_nxt = (open_rows == '0) ? ISSUE : SCAN;
      SCAN:     if (cand || last_scan) state_nxt = ISSUE;
      ISSUE:    state_nxt = last_row ? IDLE : WAIT_ROW;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx      <= '0;
      row_cnt       <= '0;
      faulty_addr_q <= '0;
      matched       <= '0;
      zmask         <= '0;
      hit_q         <= 1'b0;
      none_left_q   <= 1'b0;
      done_q        <= 1'b0;
      wr_en_q       <= 1'b0;
    end else begin
      wr_en_q <= load_acc;
      done_q  <= (state == ISSUE) && last_row;
      case (state)
        IDLE: begin
          if (start) begin
            matched <= '0;
            row_cnt <= '0;
          end
        end
        WAIT_ROW: begin
          if (row_valid) begin
            zmask       <= zero_col_mask;
            scan_idx    <= '0;
            hit_q       <= 1'b0;
            none_left_q <= (open_rows == '0);
          end
        end
        SCAN: begin
          if (cand) begin
            hit_q             <= 1'b1;
            faulty_addr_q     <= scan_idx;
            matched[scan_idx] <= 1'b1;
          end else if (!last_scan) begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        ISSUE: row_cnt <= row_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign row_ready          = (state == WAIT_ROW);
  assign busy               = (state != IDLE);
  assign match_success      = (state == ISSUE) && hit_q;
  assign all_faulty_matched = (state == ISSUE) && !hit_q && none_left_q;
  assign match_failed       = (state == ISSUE) && !hit_q && !none_left_q;
  assign faulty_addr        = faulty_addr_q;
  assign current_row_addr   = row_cnt;
  assign wr_en              = wr_en_q;
  assign done               = done_q;

`ifdef MATCH_STATS_EN
  localparam logic [ADDR_WIDTH:0] STAT_MAX = (ADDR_WIDTH+1)'(SYSTOLIC_SIZE);

  logic [ADDR_WIDTH:0] succ_q, fail_q;

  always_ff @(posedge clk) begin
    if (rst || (start && state == IDLE)) begin
      succ_q <= '0;
      fail_q <= '0;
    end else begin
      if (match_success && succ_q != STAT_MAX) succ_q <= succ_q + 1'b1;
      if (match_failed  && fail_q != STAT_MAX) fail_q <= fail_q + 1'b1;
    end
  end

  assign success_count = succ_q;
  assign failed_count  = fail_q;
`else
  assign success_count = '0;
  assign failed_count  = '0;
`endif

endmodule

// File: tb/tb_row_match_sequencer.sv
// tb_row_match_sequencer: scoreboard bench for row_match_sequencer (size 8).
module tb_row_match_sequencer;

  localparam int S = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [A-1:0] load_row;
  logic [S-1:0] load_fault_cols;
  logic         start;
  logic         row_valid;
  logic         row_ready;
  logic [S-1:0] zero_col_mask;
  logic         match_success, match_failed, all_faulty_matched;
  logic [A-1:0] faulty_addr, current_row_addr;
  logic [S-1:0] faulty_rows_mask;
  logic         wr_en, busy, done;
  logic [A:0]   success_count, failed_count;

  row_match_sequencer #(.SYSTOLIC_SIZE(S), .ADDR_WIDTH(A)) dut (
    .clk                (clk),
    .rst                (rst),
    .load_valid         (load_valid),
    .load_row           (load_row),
    .load_fault_cols    (load_fault_cols),
    .start              (start),
    .row_valid          (row_valid),
    .row_ready          (row_ready),
    .zero_col_mask      (zero_col_mask),
    .match_success      (match_success),
    .match_failed       (match_failed),
    .all_faulty_matched (all_faulty_matched),
    .faulty_addr        (faulty_addr),
    .current_row_addr   (current_row_addr),
    .faulty_rows_mask   (faulty_rows_mask),
    .wr_en              (wr_en),
    .busy               (busy),
    .done               (done),
    .success_count      (success_count),
    .failed_count       (failed_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // kind: 0 success, 1 failed, 2 all_faulty_matched
  typedef struct {
    int kind;
    int addr;
    int row;
    int at;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [S-1:0] m_bm [S];
  logic [S-1:0] m_matched;
  int           m_row;
  int           m_succ, m_fail;
  int           last_pulse = 0;

  task automatic model_clear();
    for (int r = 0; r < S; r++) m_bm[r] = '0;
    m_matched = '0;
    m_row = 0;
  endtask

  function automatic logic [S-1:0] model_mask();
    logic [S-1:0] mk;
    for (int r = 0; r < S; r++) mk[r] = |m_bm[r];
    return mk;
  endfunction

  task automatic model_row(input logic [S-1:0] z, input int hs);
    exp_t e;
    logic [S-1:0] open;
    open   = model_mask() & ~m_matched;
    e.row  = m_row;
    e.addr = -1;
    if (open == '0) begin
      e.kind = 2;
      e.at   = hs;
    end else begin
      e.kind = 1;
      e.at   = hs + S;
      for (int p = 0; p < S; p++) begin
        if (open[p] && ((m_bm[p] & ~z) == '0)) begin
          e.kind = 0;
          e.addr = p;
          e.at   = hs + p + 1;
          m_matched[p] = 1'b1;
          break;
        end
      end
    end
    if (e.kind == 0 && m_succ < S) m_succ++;
    if (e.kind == 1 && m_fail < S) m_fail++;
    m_row++;
    sb.push_back(e);
  endtask

  // Result monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (match_success || match_failed || all_faulty_matched)) begin
      chk("pulse_onehot", int'(match_success) + int'(match_failed) + int'(all_faulty_matched), 1);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("kind", match_success ? 0 : (match_failed ? 1 : 2), e.kind);
        chk("row_addr", int'(current_row_addr), e.row);
        chk("latency", cyc, e.at);
        if (e.kind == 0) chk("faulty_addr", int'(faulty_addr), e.addr);
      end
      last_pulse = cyc;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    sb.delete();
  endtask

  task automatic do_load(input int row, input logic [S-1:0] cols, input bit accept);
    @(negedge clk);
    load_valid      = 1'b1;
    load_row        = A'(row);
    load_fault_cols = cols;
    @(posedge clk);
    #1 load_valid = 1'b0;
    chk("wr_en", int'(wr_en), int'(accept));
    if (accept) m_bm[row] = cols;
    chk("faulty_rows_mask", int'(faulty_rows_mask), int'(model_mask()));
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    m_matched = '0;
    m_row  = 0;
    m_succ = 0;
    m_fail = 0;
  endtask

  task automatic send_row(input logic [S-1:0] z, input bit push);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (row_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("ready_timeout", 0, 1);
    end else begin
      row_valid     = 1'b1;
      zero_col_mask = z;
      if (push) model_row(z, cyc + 1);
      @(posedge clk);
      #1 row_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", int'(seen), 1);
    if (seen) begin
      chk("done_timing", cyc, last_pulse + 1);
      chk("idle_after_done", int'(busy), 0);
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic check_stats();
`ifdef MATCH_STATS_EN
    chk("success_count", int'(success_count), m_succ);
    chk("failed_count", int'(failed_count), m_fail);
`else
    chk("success_count", int'(success_count), 0);
    chk("failed_count", int'(failed_count), 0);
`endif
  endtask

  initial begin
    logic [S-1:0] zl [S];
    rst = 1'b1; load_valid = 1'b0; load_row = '0; load_fault_cols = '0;
    start = 1'b0; row_valid = 1'b0; zero_col_mask = '0;
    m_succ = 0; m_fail = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(row_ready), 0);
    chk("rst_mask", int'(faulty_rows_mask), 0);
    chk("rst_faddr", int'(faulty_addr), 0);
    chk("rst_rowaddr", int'(current_row_addr), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_succ_cnt", int'(success_count), 0);
    rst = 1'b0;

    // No faults: every row reports all_faulty_matched one cycle after handshake.
    do_start();
    chk("busy_after_start", int'(busy), 1);
    for (int r = 0; r < S; r++) send_row(8'h00, 1'b1);
    wait_done();

    // Single fault row 3 column 2, covered by the first logical row.
    do_reset();
    do_load(3, 8'h04, 1'b1);
    do_start();
    send_row(8'h04, 1'b1);
    for (int r = 1; r < S; r++) send_row(8'h00, 1'b1);
    wait_done();

    // Fault row 3 not covered first, then covered.
    do_reset();
    do_load(3, 8'h04, 1'b1);
    do_start();
    send_row(8'h00, 1'b1);
    send_row(8'h04, 1'b1);
    for (int r = 2; r < S; r++) send_row(8'h00, 1'b1);
    wait_done();
    check_stats();

    // Two identical fault rows: lowest index first, then the other.
    do_reset();
    do_load(2, 8'h01, 1'b1);
    do_load(5, 8'h01, 1'b1);
    do_start();
    send_row(8'h01, 1'b1);
    send_row(8'h01, 1'b1);
    for (int r = 2; r < S; r++) send_row(8'h01, 1'b1);
    wait_done();
    check_stats();

    // Randomised pass: sparse faults, random zero masks.
    do_reset();
    for (int k = 0; k < 4; k++)
      do_load(int'($urandom_range(0, S-1)), S'(1) << $urandom_range(0, S-1), 1'b1);
    do_start();
    for (int r = 0; r < S; r++) zl[r] = S'($urandom);
    for (int r = 0; r < S; r++) send_row(zl[r], 1'b1);
    wait_done();
    check_stats();

    // Load while busy is ignored; reset during SCAN aborts with no pulse.
    do_reset();
    do_load(6, 8'h80, 1'b1);
    do_start();
    do_load(1, 8'h02, 1'b0);
    send_row(8'h00, 1'b0);
    chk("busy_in_scan", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    chk("abort_busy", int'(busy), 0);
    chk("abort_mask", int'(faulty_rows_mask), 0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_quiet_busy", int'(busy), 0);
    chk("sb_final", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
